muxadd_ctrl: RTL and testbench
==============================

MUXADD_CTRL -- requirements
Module: muxadd_ctrl

Interface
REQ-001 Parameter INUM, default 8: number of mux-adder inputs; power of two, at least 2.
REQ-002 Parameter LOGINUM, default 3: log2(INUM); width of the select.
REQ-003 Parameter BITWIDTH, default 8: run length is 2^BITWIDTH cycles; sets the result width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start_valid  in  1  request to run one accumulation window.
REQ-007 start_ready  out  1  controller can accept a start.
REQ-008 clear  in  1  synchronous abort of the current window.
REQ-009 sel  out  LOGINUM  mux-adder select.
REQ-010 bs_en  out  1  enable for the external bitstream generators and mux adder.
REQ-011 mux_out  in  1  registered mux-adder output bit (one-cycle latency relative to sel).
REQ-012 res_valid  out  1  result available.
REQ-013 res_ready  in  1  consumer accepts the result.
REQ-014 result  out  BITWIDTH+1  count of ones in mux_out over the window.
REQ-015 busy  out  1  high in RUN and DRAIN.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-017 start_ready SHALL be 1 only in IDLE; a start is accepted on an edge where start_valid and start_ready are both 1.
REQ-018 On acceptance (call it edge 0), the FSM SHALL go to RUN, clear the cycle counter cnt (BITWIDTH bits) and clear the ones counter.
REQ-019 In RUN, bs_en SHALL be 1 and cnt SHALL increment every cycle.
REQ-020 RUN SHALL last exactly 2^BITWIDTH cycles and go to DRAIN on the edge where cnt wraps from all-ones to 0.
REQ-021 sel SHALL equal the bit-reversal of cnt[LOGINUM-1:0] (Sobol dimension-1 order: 0,4,2,6,1,5,3,7 for LOGINUM=3).
REQ-022 sel SHALL be 0 outside RUN.
REQ-023 The ones counter SHALL add mux_out on every edge where a 1-cycle-delayed copy of bs_en is 1, covering RUN cycles 2..N plus the DRAIN cycle.
REQ-024 DRAIN SHALL last exactly one cycle, then go to DONE with result registered; res_valid therefore rises after edge 2^BITWIDTH+1.
REQ-025 The ones counter SHALL be BITWIDTH+1 bits and SHALL neither saturate nor wrap; its maximum value is 2^BITWIDTH.
REQ-026 In DONE, res_valid SHALL be 1 and result SHALL be held stable until the res_valid and res_ready handshake, then the FSM SHALL go to IDLE.
REQ-027 start_valid SHALL be ignored outside IDLE, and no new start SHALL be accepted on the same edge as the result handshake.
REQ-028 clear=1 SHALL force IDLE on the next edge from any state and discard the counts; clear SHALL take priority over start and over the result handshake.
REQ-029 busy SHALL be 1 exactly in RUN and DRAIN.

Reset
REQ-030 While rst=1, the FSM SHALL be in IDLE and cnt, the ones counter, the delayed bs_en, result and res_valid SHALL all be 0.
REQ-031 While rst=1, the outputs SHALL be sel=0, bs_en=0 and busy=0, with start_ready=1 once rst is released.
REQ-032 rst asserted mid-window SHALL abort immediately (asynchronously); no partial result SHALL ever appear.

Structure
REQ-033 The state enum and the default parameter values SHALL live in the shared package muxadd_pkg.
REQ-034 The bit-reversed select counter SHALL be the sub-module muxadd_sel_gen (clk, rst, en, clr, sel).
REQ-035 The controller SHALL contain no arithmetic beyond the two counters; the mux adder and bitstream generators remain external.

Verification (BITWIDTH=8, INUM=8)
REQ-036 mux_out held at 1, one start -> res_valid after edge 257, result=256, busy high for 257 cycles.
REQ-037 mux_out held at 0 -> result=0.
REQ-038 mux_out = sel==0 (registered) -> result=32; first 8 sel values are 0,4,2,6,1,5,3,7.
REQ-039 res_ready held at 0 for 10 cycles after res_valid -> result and res_valid stable; start_valid pulses in that interval are not accepted (start_ready=0).
REQ-040 clear at RUN cycle 100 -> IDLE next edge; a following run with mux_out=1 gives result=256 with no residue.
REQ-041 rst pulse at RUN cycle 50 -> outputs at reset values with no clock edge; res_valid never asserted for the aborted run.

Source files
------------

// File: rtl/muxadd_pkg.sv
// ============================================================================
//  muxadd_pkg
//  Shared state encoding and default sizing for the mux-adder controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package muxadd_pkg;

    localparam int INUM_DEF     = 8;
    localparam int LOGINUM_DEF  = 3;
    localparam int BITWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muxadd_sel_gen.sv
// ============================================================================
//  muxadd_sel_gen
//  Window cycle counter producing a bit-reversed (Sobol dim-1) mux select.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module muxadd_sel_gen
    import muxadd_pkg::*;
#(
    parameter int INUM     = INUM_DEF,
    parameter int LOGINUM  = LOGINUM_DEF,
    parameter int BITWIDTH = BITWIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    output logic [LOGINUM-1:0] sel,
    output logic               last
);

    localparam logic [LOGINUM-1:0] c_sel_mask = LOGINUM'(INUM - 1);

    logic [BITWIDTH-1:0] r_cnt;
    logic [LOGINUM-1:0]  w_rev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + BITWIDTH'(1);
        end
    end

    for (genvar gi = 0; gi < LOGINUM; gi++) begin : g_rev
        assign w_rev[gi] = r_cnt[LOGINUM-1-gi];
    end

    assign sel  = en ? (w_rev & c_sel_mask) : '0;
    // Final RUN cycle: the next enabled edge wraps the counter to zero.
    assign last = en & (&r_cnt);

endmodule

`default_nettype wire

// File: rtl/muxadd_ctrl.sv
// ============================================================================
//  muxadd_ctrl
//  Runs one 2^BITWIDTH-cycle mux-adder window and counts the ones it returns.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module muxadd_ctrl
    import muxadd_pkg::*;
#(
    parameter int INUM     = INUM_DEF,
    parameter int LOGINUM  = LOGINUM_DEF,
    parameter int BITWIDTH = BITWIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic                clear,
    output logic [LOGINUM-1:0]  sel,
    output logic                bs_en,
    input  logic                mux_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [BITWIDTH:0]   result,
    output logic                busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_run;
    logic               w_accept;
    logic               w_clr_cnt;
    logic               w_last;
    logic               r_bs_en_d;
    logic [BITWIDTH:0]  r_ones;
    logic [BITWIDTH:0]  w_ones_nxt;
    logic [BITWIDTH:0]  r_result;

    assign w_run       = (r_state == ST_RUN);
    assign start_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept    = start_ready & start_valid & ~clear;
    assign w_clr_cnt   = w_accept | clear;

    muxadd_sel_gen #(
        .INUM     (INUM),
        .LOGINUM  (LOGINUM),
        .BITWIDTH (BITWIDTH)
    ) u_sel_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_run),
        .clr  (w_clr_cnt),
        .sel  (sel),
        .last (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start_valid) w_state_nxt = ST_RUN;
                ST_RUN:   if (w_last)      w_state_nxt = ST_DRAIN;
                ST_DRAIN:                  w_state_nxt = ST_DONE;
                ST_DONE:  if (res_ready)   w_state_nxt = ST_IDLE;
                default:                   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // mux_out lags sel by one cycle, so samples are qualified by the delayed enable;
    // the DRAIN edge captures the final sample straight into the result.
    assign w_ones_nxt = r_ones + {{BITWIDTH{1'b0}}, mux_out};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bs_en_d <= 1'b0;
            r_ones    <= '0;
            r_result  <= '0;
        end else if (clear) begin
            r_bs_en_d <= 1'b0;
            r_ones    <= '0;
            r_result  <= '0;
        end else begin
            r_bs_en_d <= w_run;
            if (w_accept) begin
                r_ones <= '0;
            end else if (r_bs_en_d) begin
                r_ones <= w_ones_nxt;
            end
            if (r_state == ST_DRAIN) begin
                r_result <= w_ones_nxt;
            end
        end
    end

    assign bs_en     = w_run;
    assign busy      = w_run | (r_state == ST_DRAIN);
    assign res_valid = (r_state == ST_DONE);
    assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muxadd_ctrl.sv
// ============================================================================
//  tb_muxadd_ctrl
//  Self-checking bench: cycle-count reference model plus directed scenarios.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muxadd_ctrl;

    localparam int INUM     = 8;
    localparam int LOGINUM  = 3;
    localparam int BITWIDTH = 8;
    localparam int N        = 1 << BITWIDTH;

    logic                clk         = 1'b0;
    logic                rst         = 1'b1;
    logic                start_valid = 1'b0;
    logic                clear       = 1'b0;
    logic                mux_out     = 1'b0;
    logic                res_ready   = 1'b0;
    logic                start_ready;
    logic                bs_en;
    logic                res_valid;
    logic                busy;
    logic [LOGINUM-1:0]  sel;
    logic [BITWIDTH:0]   result;

    int n_tests  = 0;
    int n_fail   = 0;
    int mux_mode = 0;
    bit cmp_en   = 1'b0;
    int sel_log [8];

    always #5 clk = ~clk;

    muxadd_ctrl #(
        .INUM     (INUM),
        .LOGINUM  (LOGINUM),
        .BITWIDTH (BITWIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .clear       (clear),
        .sel         (sel),
        .bs_en       (bs_en),
        .mux_out     (mux_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .busy        (busy)
    );

    // External registered mux adder stand-in: 0 = all zeros, 1 = all ones, 2 = (sel==0)
    always @(posedge clk or posedge rst) begin
        if (rst)                mux_out <= 1'b0;
        else if (mux_mode == 0) mux_out <= 1'b0;
        else if (mux_mode == 1) mux_out <= 1'b1;
        else                    mux_out <= (sel == '0);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int bitrev3(input int v);
        int r = 0;
        for (int i = 0; i < 3; i++)
            if ((v & (1 << i)) != 0) r |= 1 << (2 - i);
        return r;
    endfunction

    // Reference model: mode 0 idle, 1 window active (m_t edges since acceptance), 2 result held
    int m_mode = 0;
    int m_t    = 0;
    int m_ones = 0;
    int m_res  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_t    = 0;
            m_ones = 0;
        end else if (clear) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (start_valid) begin
                       m_mode = 1;
                       m_t    = 0;
                       m_ones = 0;
                   end
                1: begin
                       m_t++;
                       if (m_t >= 2) m_ones += int'(mux_out);
                       if (m_t == N + 1) begin
                           m_mode = 2;
                           m_res  = m_ones;
                       end
                   end
                2: if (res_ready) m_mode = 0;
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit exp_bs;
            exp_bs = (m_mode == 1) && (m_t < N);
            chk("busy",        int'(busy),        int'(m_mode == 1));
            chk("bs_en",       int'(bs_en),       int'(exp_bs));
            chk("sel",         int'(sel),         exp_bs ? bitrev3(m_t % INUM) : 0);
            chk("res_valid",   int'(res_valid),   int'(m_mode == 2));
            chk("start_ready", int'(start_ready), int'((m_mode == 0) && !rst));
            if (m_mode == 2) chk("result", int'(result), m_res);
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic run_window(input int mode, output int res, output int bc, output int lat);
        bit done = 1'b0;
        mux_mode    = mode;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        bc  = 0;
        lat = 0;
        res = -1;
        for (int k = 0; k < 400 && !done; k++) begin
            if (k < 8) sel_log[k] = int'(sel);
            if (busy) bc++;
            if (res_valid) begin
                done = 1'b1;
                lat  = k;
                res  = int'(result);
            end else begin
                step();
            end
        end
        if (!done) chk("res_valid_timeout", 0, 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("hs_start_ready", int'(start_ready), 1);
        chk("hs_res_valid",   int'(res_valid),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int res, bc, lat, seen;
        int exp_sel [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

        repeat (3) @(negedge clk);
        #2;
        chk("rst_sel",       int'(sel),       0);
        chk("rst_bs_en",     int'(bs_en),     0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_result",    int'(result),    0);
        rst    = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("rel_start_ready", int'(start_ready), 1);
        step();

        // All ones: full-scale count, 257 busy cycles, result after edge 257
        run_window(1, res, bc, lat);
        chk("ones_result",  res, 256);
        chk("ones_busy",    bc,  257);
        chk("ones_latency", lat, 257);
        handshake();

        // All zeros
        run_window(0, res, bc, lat);
        chk("zeros_result", res, 0);
        handshake();

        // mux_out = registered (sel==0): one hit per 8-cycle Sobol period
        run_window(2, res, bc, lat);
        chk("sel0_result", res, 32);
        for (int k = 0; k < 8; k++) chk("sel_order", sel_log[k], exp_sel[k]);
        handshake();

        // Back-pressure: result held, starts ignored while DONE
        run_window(1, res, bc, lat);
        for (int k = 0; k < 10; k++) begin
            start_valid = (k % 3 == 0);
            step();
            chk("bp_res_valid",   int'(res_valid),   1);
            chk("bp_result",      int'(result),      256);
            chk("bp_start_ready", int'(start_ready), 0);
        end
        // Start offered on the handshake edge must not be taken
        start_valid = 1'b1;
        res_ready   = 1'b1;
        step();
        start_valid = 1'b0;
        res_ready   = 1'b0;
        chk("hs_edge_idle", int'(start_ready), 1);
        chk("hs_edge_busy", int'(busy),        0);
        step();
        chk("hs_edge_busy2", int'(busy), 0);

        // clear mid-run, then a clean run
        mux_mode    = 1;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (99) step();
        chk("pre_clear_busy", int'(busy), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_start_ready", int'(start_ready), 1);
        chk("clear_busy",        int'(busy),        0);
        chk("clear_bs_en",       int'(bs_en),       0);
        run_window(1, res, bc, lat);
        chk("post_clear_result", res, 256);
        handshake();

        // Asynchronous reset mid-run
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (50) step();
        rst = 1'b1;
        #1;
        chk("arst_sel",       int'(sel),       0);
        chk("arst_bs_en",     int'(bs_en),     0);
        chk("arst_busy",      int'(busy),      0);
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_result",    int'(result),    0);
        step();
        rst = 1'b0;
        #1;
        chk("arst_rel_start_ready", int'(start_ready), 1);
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (res_valid) seen++;
        end
        chk("arst_no_result", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
